instr_fetch: RTL and testbench



---
 rtl/instr_fetch_if.sv | 38 +++
 rtl/instr_fetch.sv | 137 +++++++++++++
 tb/tb_instr_fetch.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response, branch redirect and decode-side handshake.
// fetch_fault is present only when IFETCH_MISALIGN_TRAP_EN is defined.
interface instr_fetch_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [XLEN-1:0] instr_pc;
  logic [XLEN-1:0] instr_pc_plus4;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic            fetch_fault;
`endif

  modport master (
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready,
`ifdef IFETCH_MISALIGN_TRAP_EN
    output fetch_fault,
`endif
    output imem_req_valid, imem_addr, instr_valid, instr, opcode, instr_pc, instr_pc_plus4
  );

  modport slave (
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready,
`ifdef IFETCH_MISALIGN_TRAP_EN
    input  fetch_fault,
`endif
    input  imem_req_valid, imem_addr, instr_valid, instr, opcode, instr_pc, instr_pc_plus4
  );
endinterface

// File: rtl/instr_fetch.sv
// RV32I fetch: credit-limited in-order imem requests, response FIFO to decode (>=1 cycle after rsp); stalls on !imem_req_ready, holds FIFO on !instr_ready.
// Redirects flush and drop in-flight words; IFETCH_MISALIGN_TRAP_EN adds a HALT state and fetch_fault on misaligned targets.
module instr_fetch #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int CUW = CW + 1;
  localparam int PW  = $clog2(FIFO_DEPTH);

`ifdef IFETCH_MISALIGN_TRAP_EN
  typedef enum logic {FETCH, HALT} state_e;
`else
  typedef enum logic {FETCH} state_e;
`endif

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [31:0]     word_q [FIFO_DEPTH];
  logic [XLEN-1:0] wpc_q  [FIFO_DEPTH];

  logic            push;
  logic            pop;
  logic            req_fire;
  logic [CW-1:0]   rsp_dec;
  logic [CUW-1:0]  credit_used;
  logic [XLEN-1:0] tgt_pc;
  logic [XLEN-1:0] rsp_pc;
  logic            nonempty;

  assign tgt_pc      = bus.redirect_pc & ~XLEN'(3);
  assign credit_used = CUW'(out_q) + CUW'(cnt_q);
  assign nonempty    = (cnt_q != '0);
  assign rsp_dec     = CW'(bus.imem_rsp_valid && (out_q != '0));
  // Oldest outstanding request; only meaningful once all dropped words have drained.
  assign rsp_pc      = pc_q - (XLEN'(out_q) << 2);

  assign bus.imem_req_valid = !reset && !bus.redirect_valid && (state_q == FETCH) &&
                              (credit_used < CUW'(FIFO_DEPTH));
  assign bus.imem_addr      = pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign bus.instr_valid    = !reset && nonempty && !bus.redirect_valid;
  assign pop                = bus.instr_valid && bus.instr_ready;
  assign bus.instr          = nonempty ? word_q[rd_q] : '0;
  assign bus.opcode         = bus.instr[6:0];
  assign bus.instr_pc       = nonempty ? wpc_q[rd_q] : '0;
  assign bus.instr_pc_plus4 = nonempty ? wpc_q[rd_q] + XLEN'(4) : '0;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign        = (bus.redirect_pc[1:0] != 2'b00);
  assign bus.fetch_fault = (state_q == HALT);
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    out_d   = out_q;
    drop_d  = drop_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    push    = 1'b0;
    if (bus.redirect_valid) begin
      // Everything still in flight, minus the word arriving now, becomes garbage.
      pc_d   = tgt_pc;
      out_d  = out_q - rsp_dec;
      drop_d = out_q - rsp_dec;
      cnt_d  = '0;
      rd_d   = '0;
      wr_d   = '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      state_d = misalign ? HALT : FETCH;
`endif
    end else begin
      if (req_fire) begin
        pc_d = pc_q + XLEN'(4);
      end
      if (bus.imem_rsp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          push = 1'b1;
        end
      end
      out_d = out_q + CW'(req_fire) - rsp_dec;
      if (push) begin
        wr_d = wr_q + PW'(1);
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      drop_q  <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      word_q[wr_q] <= bus.imem_rsp_data;
      wpc_q[wr_q]  <= rsp_pc;
    end
  end

  a_rsp_has_request: assert property (@(posedge clk) disable iff (reset)
    bus.imem_rsp_valid |-> (out_q != '0));
endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: in-order memory model, expected decode stream derived from sequential PCs since the last redirect.
module tb_instr_fetch;
  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          DEPTH    = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_if #(.XLEN(XLEN)) bus ();

  instr_fetch #(.XLEN(XLEN), .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct {
    logic [31:0] addr;
    int          acc;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] fetch_ptr;
  bit          halted;
  int          n_cmp, n_bad, cyc, n_acc, n_pop;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h0019_660D + 32'h3C6E_F35F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, expv);
    end
  endtask

  task automatic model_redirect(input logic [31:0] tgt);
    exp_q.delete();
`ifdef IFETCH_MISALIGN_TRAP_EN
    if (tgt[1:0] != 2'b00) begin
      halted = 1'b1;
    end else begin
      halted    = 1'b0;
      fetch_ptr = tgt;
    end
`else
    fetch_ptr = {tgt[31:2], 2'b00};
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    cyc++;
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.imem_req_ready = 1'b0;
    bus.instr_ready    = 1'b0;
    pend_q.delete();
    exp_q.delete();
    halted    = 1'b0;
    fetch_ptr = RESET_PC;
    repeat (2) @(negedge clk);
    cyc += 2;
    #1;
    chk("rst_req_valid", bus.imem_req_valid, 0);
    chk("rst_instr_valid", bus.instr_valid, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_opcode", bus.opcode, 0);
    chk("rst_instr_pc", bus.instr_pc, 0);
    chk("rst_pc_plus4", bus.instr_pc_plus4, 0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    chk("rst_fault", bus.fetch_fault, 0);
`endif
    @(negedge clk);
    cyc++;
    reset = 1'b0;
    #1;
    chk("first_req_valid", bus.imem_req_valid, 1);
    chk("first_req_addr", bus.imem_addr, RESET_PC);
  endtask

  // One cycle: drive inputs at negedge, then account for transfers at the next posedge.
  task automatic step(input int p_rdr, input logic [31:0] tgt, input int p_rsp,
                      input int p_mrdy, input int p_irdy);
    bit rdr;
    bit rsp;
    @(negedge clk);
    cyc++;
    rdr = ($urandom_range(99) < p_rdr);
    bus.redirect_valid = rdr;
    bus.redirect_pc    = tgt;
    rsp = (pend_q.size() > 0) && (pend_q[0].acc < cyc) && ($urandom_range(99) < p_rsp);
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? mem_word(pend_q[0].addr) : $urandom;
    if (rsp) void'(pend_q.pop_front());
    bus.imem_req_ready = ($urandom_range(99) < p_mrdy);
    bus.instr_ready    = ($urandom_range(99) < p_irdy);
    if (rdr) model_redirect(tgt);
    #1;
    if (rdr) chk("redirect_no_req", bus.imem_req_valid, 0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    if (!rdr) begin
      chk("fetch_fault", bus.fetch_fault, halted);
      if (halted) chk("halt_no_req", bus.imem_req_valid, 0);
    end
`endif
    if (bus.imem_req_valid) begin
      chk("req_addr", bus.imem_addr, fetch_ptr);
      if (bus.imem_req_ready) begin
        pend_q.push_back('{addr: fetch_ptr, acc: cyc});
        exp_q.push_back(fetch_ptr);
        fetch_ptr += 32'd4;
        n_acc++;
      end
    end
  endtask

  // Monitor: checks every instruction handed to decode against the expected stream.
  initial begin
    logic [31:0] e;
    logic [31:0] w;
    forever begin
      @(negedge clk);
      #2;
      if (reset !== 1'b1) begin
        if (bus.redirect_valid) chk("redirect_no_instr", bus.instr_valid, 0);
        if (bus.instr_valid && bus.instr_ready) begin
          n_pop++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_instr: got pc %08h with none expected", bus.instr_pc);
          end else begin
            e = exp_q.pop_front();
            w = mem_word(e);
            chk("instr_pc", bus.instr_pc, e);
            chk("instr_word", bus.instr, w);
            chk("opcode", {25'd0, bus.opcode}, {25'd0, w[6:0]});
            chk("instr_pc_plus4", bus.instr_pc_plus4, e + 32'd4);
          end
        end
      end
    end
  end

  initial begin
    int p0;
    int a0;
    logic [31:0] t;
    n_cmp = 0; n_bad = 0; cyc = 0; n_acc = 0; n_pop = 0;
    reset = 1'b1;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    bus.imem_req_ready = 1'b0; bus.instr_ready = 1'b0;

    // Sequential streaming with everything ready.
    do_reset();
    p0 = n_pop;
    repeat (30) step(0, 0, 100, 100, 100);
    n_cmp++;
    if (n_pop - p0 < 15) begin
      n_bad++;
      $display("FAIL stream_progress: got %0d pops required at least 15", n_pop - p0);
    end

    // Decode backpressure: only FIFO_DEPTH requests may be issued.
    do_reset();
    a0 = n_acc;
    repeat (10) step(0, 0, 100, 100, 0);
    chk("backpressure_reqs", n_acc - a0, DEPTH);
    repeat (10) step(0, 0, 100, 100, 100);

    // Memory stall: address holds at 0x4.
    do_reset();
    step(0, 0, 100, 100, 100);
    repeat (5) step(0, 0, 100, 0, 100);
    chk("stall_addr", bus.imem_addr, 32'h4);
    repeat (8) step(0, 0, 100, 100, 100);

    // Redirect with two requests outstanding.
    do_reset();
    repeat (3) step(0, 0, 0, 100, 0);
    chk("two_outstanding", pend_q.size(), 2);
    step(100, 32'h100, 0, 100, 100);
    repeat (12) step(0, 0, 100, 100, 100);

    // Redirect coinciding with a response while the FIFO holds a word.
    do_reset();
    step(0, 0, 0, 100, 0);
    step(0, 0, 100, 100, 0);
    step(100, 32'h40, 100, 100, 100);
    repeat (10) step(0, 0, 100, 100, 100);

    // Redirect coinciding with a response while two are outstanding.
    do_reset();
    step(0, 0, 0, 100, 0);
    step(0, 0, 0, 100, 0);
    step(100, 32'h80, 100, 100, 100);
    repeat (10) step(0, 0, 100, 100, 100);

    // Back-to-back redirects, then PC wrap-around.
    step(100, 32'h300, 100, 100, 100);
    step(100, 32'h340, 100, 100, 100);
    repeat (10) step(0, 0, 100, 100, 100);
    step(100, 32'hFFFF_FFF8, 100, 100, 100);
    repeat (12) step(0, 0, 100, 100, 100);

    // Misaligned redirect target.
    step(100, 32'h102, 100, 100, 100);
    repeat (6) step(0, 0, 100, 100, 100);
    step(100, 32'h200, 100, 100, 100);
    repeat (10) step(0, 0, 100, 100, 100);

    // Randomized traffic with occasional redirects and one mid-run reset.
    for (int i = 0; i < 1500; i++) begin
      t = $urandom & 32'h0000_3FFC;
      if ($urandom_range(9) == 0) t[1:0] = 2'($urandom_range(1, 3));
      step(4, t, 60, 70, 60);
      if (i == 700) do_reset();
    end
    repeat (20) step(0, 0, 100, 100, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
